modinv_helper_reduce_precalc: RTL and testbench

Word-serial pre-computation stage of the modular invertor's reduce step, directly upstream of the reduce/update stage. On each `ena` pulse it reads operand s and modulus q from word buffers (LSW first) and writes two candidate results: u = s >> 1 and v = (s + q) >> 1. It also produces the `s_is_odd` flag that the downstream update stage uses to choose between u and v.

---
 rtl/modinv_pkg.sv | 24 ++
 rtl/modinv_helper_adder32.sv | 15 +
 rtl/modinv_helper_reduce_precalc.sv | 142 ++++++++++++++
 tb/tb_modinv_helper_reduce_precalc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/modinv_pkg.sv
// Shared definitions for the modular invertor helper stages: word width and
// counter sizing helpers.
package modinv_pkg;

    localparam int MODINV_WORD_W = 32;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    // Sequencer states run 0..N+2, so N+3 distinct counts.
    function automatic int proc_cnt_bits(input int num_words);
        return clog2(num_words + 3);
    endfunction

endpackage

// File: rtl/modinv_helper_adder32.sv
// Combinational 32-bit adder with carry-in and carry-out, shared by the
// modular invertor helper stages.
module modinv_helper_adder32
    import modinv_pkg::*;
(
    input  logic [MODINV_WORD_W-1:0] a,
    input  logic [MODINV_WORD_W-1:0] b,
    input  logic                     c_in,
    output logic [MODINV_WORD_W-1:0] sum,
    output logic                     c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{MODINV_WORD_W{1'b0}}, c_in};

endmodule

// File: rtl/modinv_helper_reduce_precalc.sv
// Word-serial precalc for the reduce step: u = s >> 1, v = (s + q) >> 1,
// plus the registered parity of s used downstream to pick between them.
//
//   proc_cnt | meaning
//   0        | idle, rdy high, waiting for ena
//   1..N     | read word cnt-1 from s/q buffers
//   2..N+1   | word cnt-2 arrives, add and register
//   3..N+2   | write u/v word cnt-3
module modinv_helper_reduce_precalc
    import modinv_pkg::*;
#(
    parameter int BUFFER_NUM_WORDS = 9,
    parameter int BUFFER_ADDR_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    output logic                        rdy,
    output logic [BUFFER_ADDR_BITS-1:0] s_addr,
    input  logic [MODINV_WORD_W-1:0]    s_din,
    output logic [BUFFER_ADDR_BITS-1:0] q_addr,
    input  logic [MODINV_WORD_W-1:0]    q_din,
    output logic [BUFFER_ADDR_BITS-1:0] u_addr,
    output logic                        u_wren,
    output logic [MODINV_WORD_W-1:0]    u_dout,
    output logic [BUFFER_ADDR_BITS-1:0] v_addr,
    output logic                        v_wren,
    output logic [MODINV_WORD_W-1:0]    v_dout,
    output logic                        s_is_odd
);

    localparam int N     = BUFFER_NUM_WORDS;
    localparam int CNT_W = proc_cnt_bits(N);

    localparam logic [CNT_W-1:0] CNT_IDLE     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ARR_FST  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_WR_FST   = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_RD_LST   = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ARR_LST  = CNT_W'(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(N + 2);

    logic [CNT_W-1:0] proc_cnt;
    logic [CNT_W-1:0] proc_cnt_nxt;

    logic rd_phase;
    logic arr_phase;
    logic arr_first;
    logic wr_phase;
    logic wr_last;

    logic [MODINV_WORD_W-1:0] s_prev;
    logic [MODINV_WORD_W-1:0] sum_prev;
    logic                     carry;

    logic [MODINV_WORD_W-1:0] sum_cur;
    logic                     carry_cur;
    logic                     add_c_in;
    logic                     u_hi;
    logic                     v_hi;

    always_comb begin
        proc_cnt_nxt = proc_cnt;
        if (proc_cnt == CNT_IDLE) begin
            if (ena) begin
                proc_cnt_nxt = CNT_ONE;
            end
        end else if (proc_cnt == CNT_LAST) begin
            proc_cnt_nxt = CNT_IDLE;
        end else begin
            proc_cnt_nxt = proc_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proc_cnt <= CNT_IDLE;
        end else begin
            proc_cnt <= proc_cnt_nxt;
        end
    end

    assign rdy       = (proc_cnt == CNT_IDLE);
    assign rd_phase  = (proc_cnt >= CNT_ONE)     && (proc_cnt <= CNT_RD_LST);
    assign arr_phase = (proc_cnt >= CNT_ARR_FST) && (proc_cnt <= CNT_ARR_LST);
    assign arr_first = (proc_cnt == CNT_ARR_FST);
    assign wr_phase  = (proc_cnt >= CNT_WR_FST)  && (proc_cnt <= CNT_LAST);
    assign wr_last   = (proc_cnt == CNT_LAST);

    assign s_addr = rd_phase ? BUFFER_ADDR_BITS'(proc_cnt - CNT_ONE)    : '0;
    assign q_addr = s_addr;
    assign u_addr = wr_phase ? BUFFER_ADDR_BITS'(proc_cnt - CNT_WR_FST) : '0;
    assign v_addr = u_addr;
    assign u_wren = wr_phase;
    assign v_wren = wr_phase;

    // Word 0 starts a fresh chain, so a carry left by an aborted run is ignored.
    assign add_c_in = arr_first ? 1'b0 : carry;

    modinv_helper_adder32 u_adder (
        .a     (s_din),
        .b     (q_din),
        .c_in  (add_c_in),
        .sum   (sum_cur),
        .c_out (carry_cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev   <= '0;
            sum_prev <= '0;
            carry    <= 1'b0;
            s_is_odd <= 1'b0;
        end else begin
            if (arr_phase) begin
                s_prev   <= s_din;
                sum_prev <= sum_cur;
                carry    <= carry_cur;
            end
            if (arr_first) begin
                s_is_odd <= s_din[0];
            end
        end
    end

    // Bit 31 of each shifted word comes from bit 0 of the word now on the bus;
    // the top word takes zero for u and the final carry for v.
    always_comb begin
        u_hi = 1'b0;
        v_hi = 1'b0;
        if (wr_last) begin
            v_hi = carry;
        end else if (wr_phase) begin
            u_hi = s_din[0];
            v_hi = sum_cur[0];
        end
    end

    assign u_dout = {u_hi, s_prev[MODINV_WORD_W-1:1]};
    assign v_dout = {v_hi, sum_prev[MODINV_WORD_W-1:1]};

endmodule

// File: tb/tb_modinv_helper_reduce_precalc.sv
// Scoreboard bench for modinv_helper_reduce_precalc: a 288-bit reference
// model pushes expected u/v words per run, the write monitor pops and compares.
module tb_modinv_helper_reduce_precalc;

    localparam int N  = 9;
    localparam int AW = 4;
    localparam int BW = 32 * N;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   u;
        logic [31:0]   v;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          rdy;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_din;
    logic [AW-1:0] q_addr;
    logic [31:0]   q_din;
    logic [AW-1:0] u_addr;
    logic          u_wren;
    logic [31:0]   u_dout;
    logic [AW-1:0] v_addr;
    logic          v_wren;
    logic [31:0]   v_dout;
    logic          s_is_odd;

    logic [31:0] s_mem [16];
    logic [31:0] q_mem [16];

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_odd = 1'b0;

    modinv_helper_reduce_precalc #(
        .BUFFER_NUM_WORDS (N),
        .BUFFER_ADDR_BITS (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .rdy      (rdy),
        .s_addr   (s_addr),
        .s_din    (s_din),
        .q_addr   (q_addr),
        .q_din    (q_din),
        .u_addr   (u_addr),
        .u_wren   (u_wren),
        .u_dout   (u_dout),
        .v_addr   (v_addr),
        .v_wren   (v_wren),
        .v_dout   (v_dout),
        .s_is_odd (s_is_odd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        s_din <= s_mem[s_addr];
        q_din <= q_mem[q_addr];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (u_wren || v_wren)) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {63'b0, u_wren}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("u_addr",  u_addr, mon_e.addr);
                chk("v_addr",  v_addr, mon_e.addr);
                chk("v_wren",  v_wren, u_wren);
                chk("u_dout",  u_dout, mon_e.u);
                chk("v_dout",  v_dout, mon_e.v);
                chk("wr_cyc",  cyc,    mon_e.cyc);
                chk("q_addr",  q_addr, s_addr);
            end
        end
    end

    task automatic load_mem(input logic [BW-1:0] s, input logic [BW-1:0] q);
        for (int w = 0; w < N; w++) begin
            s_mem[w] = s[32*w +: 32];
            q_mem[w] = q[32*w +: 32];
        end
    endtask

    // Called at the negedge just before the accepting posedge.
    task automatic push_run(input logic [BW-1:0] s, input logic [BW-1:0] q);
        logic [BW:0]   sum;
        logic [BW-1:0] u;
        logic [BW-1:0] v;
        exp_t          e;
        sum = {1'b0, s} + {1'b0, q};
        u   = s >> 1;
        v   = sum[BW:1];
        for (int j = 0; j < N; j++) begin
            e.addr = AW'(j);
            e.u    = u[32*j +: 32];
            e.v    = v[32*j +: 32];
            e.cyc  = cyc + 3 + j;
            sb.push_back(e);
        end
        exp_odd = s[0];
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_wait", {63'b0, rdy}, 64'd1);
    endtask

    task automatic run_vec(input string name, input logic [BW-1:0] s, input logic [BW-1:0] q);
        int t0;
        wait_rdy();
        load_mem(s, q);
        push_run(s, q);
        t0  = cyc;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        wait_rdy();
        chk({name, "_latency"}, cyc - t0, 64'd12);
        chk({name, "_drain"}, sb.size(), 64'd0);
        chk({name, "_odd"}, {63'b0, s_is_odd}, {63'b0, exp_odd});
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_rdy"},    {63'b0, rdy},      64'd1);
        chk({name, "_u_wren"}, {63'b0, u_wren},   64'd0);
        chk({name, "_v_wren"}, {63'b0, v_wren},   64'd0);
        chk({name, "_odd"},    {63'b0, s_is_odd}, 64'd0);
        chk({name, "_s_addr"}, s_addr, 64'd0);
        chk({name, "_q_addr"}, q_addr, 64'd0);
        chk({name, "_u_addr"}, u_addr, 64'd0);
        chk({name, "_v_addr"}, v_addr, 64'd0);
        chk({name, "_u_dout"}, u_dout, 64'd0);
        chk({name, "_v_dout"}, v_dout, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] s;
        logic [BW-1:0] q;
        int t0;

        for (int w = 0; w < 16; w++) begin
            s_mem[w] = 32'h0;
            q_mem[w] = 32'h0;
        end
        rst = 1'b1;
        ena = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // even s
        s = BW'(6);
        q = {BW{1'b1}};
        q[31:0] = 32'hFFFF_FFF1;
        run_vec("even", s, q);

        // odd s, carry ripples through every word
        s = BW'(1);
        q = {32'h7FFF_FFFF, {(BW-32){1'b1}}};
        run_vec("carry", s, q);

        // top carry out of the final word
        q = '0;
        for (int w = 0; w < N; w++) q[32*w +: 32] = $urandom;
        q[BW-1] = 1'b1;
        q[0]    = 1'b1;
        s = q - BW'(2);
        run_vec("topcarry", s, q);

        // bit 0 of word 1 shifts into bit 31 of word 0
        s = '0;
        s[32] = 1'b1;
        q = {BW{1'b1}};
        run_vec("xshift", s, q);

        // random operands with s < q, q odd
        for (int k = 0; k < 3; k++) begin
            q = '0;
            s = '0;
            for (int w = 0; w < N; w++) begin
                q[32*w +: 32] = $urandom;
                s[32*w +: 32] = $urandom;
            end
            q[BW-1 -: 32] = q[BW-1 -: 32] | 32'h0000_1000;
            s[BW-1 -: 32] = q[BW-1 -: 32] >> 1;
            q[0] = 1'b1;
            run_vec("rand", s, q);
        end

        // ena held high: back-to-back runs, busy ena ignored
        s = '0;
        q = {BW{1'b1}};
        for (int w = 0; w < N; w++) s[32*w +: 32] = $urandom;
        s[BW-1] = 1'b0;
        s[0]    = 1'b1;
        wait_rdy();
        load_mem(s, q);
        ena = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push_run(s, q);
            t0 = cyc;
            @(negedge clk);
            if (r == 2) ena = 1'b0;
            wait_rdy();
            chk("b2b_period", cyc - t0, 64'd12);
        end
        chk("b2b_drain", sb.size(), 64'd0);
        chk("b2b_odd", {63'b0, s_is_odd}, {63'b0, exp_odd});
        @(negedge clk);
        chk("b2b_stop", {63'b0, rdy}, 64'd1);

        // reset asserted at cnt 5 of a run with odd s
        s = BW'(32'h0000_0123);
        q = {BW{1'b1}};
        load_mem(s, q);
        push_run(s, q);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_odd_before", {63'b0, s_is_odd}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("abort");
        sb.delete();
        rst = 1'b0;
        @(negedge clk);

        s = '0;
        s[32*4 +: 32] = 32'h8000_0001;
        s[0] = 1'b1;
        q = {BW{1'b1}};
        q[BW-1] = 1'b0;
        run_vec("post_abort", s, q);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
